// File: rtl/alu_hilo_unit_if.sv
// Command/result bundle between the EX stage and the HI/LO sequencer.
// The EX stage (master) issues commands; the sequencer (slave) returns HI/LO and status.
interface alu_hilo_unit_if;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        hilo_busy;
  logic        hilo_done;

  modport master (
    output cmd_valid, cmd, cmd_a, cmd_b,
    input  cmd_ready, hi, lo, hilo_busy, hilo_done
  );

  modport slave (
    input  cmd_valid, cmd, cmd_a, cmd_b,
    output cmd_ready, hi, lo, hilo_busy, hilo_done
  );
endinterface

// File: rtl/alu_hilo_unit.sv
// HI/LO register file and MULT/MULTU sequencer: drives the 32-bit multiplier for the low
// word, then the high word, and captures both halves; also handles MTHI/MTLO writes.
module alu_hilo_unit #(
  parameter int               OPC_W      = 5,
  parameter logic [OPC_W-1:0] OPC_IDLE   = '0,
  parameter logic [OPC_W-1:0] OPC_MULTL  = 5'd24,
  parameter logic [OPC_W-1:0] OPC_MULTH  = 5'd25,
  parameter logic [OPC_W-1:0] OPC_MULTLU = 5'd26,
  parameter logic [OPC_W-1:0] OPC_MULTHU = 5'd27
) (
  input  logic              CLK,
  input  logic              RST,
  alu_hilo_unit_if.slave    ex,
  output logic [OPC_W-1:0]  mul_opcode,
  output logic [31:0]       mul_src1,
  output logic [31:0]       mul_src2,
  input  logic [31:0]       mul_result,
  input  logic              mul_busy,
  input  logic              mul_done
);

  localparam logic [2:0] CMD_MULT  = 3'd1;
  localparam logic [2:0] CMD_MULTU = 3'd2;
  localparam logic [2:0] CMD_MTHI  = 3'd3;
  localparam logic [2:0] CMD_MTLO  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LO_REQ  = 3'd1,
    S_LO_WAIT = 3'd2,
    S_HI_REQ  = 3'd3,
    S_HI_WAIT = 3'd4
  } state_t;

  state_t           state_reg;
  logic [OPC_W-1:0] opcode_reg;
  logic [31:0]      src1_reg;
  logic [31:0]      src2_reg;
  logic             sign_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic             done_reg;

  // The multiplier's busy flag carries no information the done pulse does not already give.
  logic mul_busy_unused;
  assign mul_busy_unused = mul_busy;

  // Opcode is registered together with the state, so each request lasts exactly one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      opcode_reg <= OPC_IDLE;
      src1_reg   <= '0;
      src2_reg   <= '0;
      sign_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (ex.cmd_valid) begin
            case (ex.cmd)
              CMD_MULT, CMD_MULTU: begin
                src1_reg   <= ex.cmd_a;
                src2_reg   <= ex.cmd_b;
                sign_reg   <= (ex.cmd == CMD_MULT);
                opcode_reg <= (ex.cmd == CMD_MULT) ? OPC_MULTL : OPC_MULTLU;
                state_reg  <= S_LO_REQ;
              end
              CMD_MTHI: hi_reg <= ex.cmd_a;
              CMD_MTLO: lo_reg <= ex.cmd_a;
              default: ;
            endcase
          end
        end
        S_LO_REQ: begin
          opcode_reg <= OPC_IDLE;
          state_reg  <= S_LO_WAIT;
        end
        S_LO_WAIT: begin
          if (mul_done) begin
            lo_reg     <= mul_result;
            opcode_reg <= sign_reg ? OPC_MULTH : OPC_MULTHU;
            state_reg  <= S_HI_REQ;
          end
        end
        S_HI_REQ: begin
          opcode_reg <= OPC_IDLE;
          state_reg  <= S_HI_WAIT;
        end
        S_HI_WAIT: begin
          if (mul_done) begin
            hi_reg    <= mul_result;
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          opcode_reg <= OPC_IDLE;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

  assign ex.cmd_ready = (state_reg == S_IDLE);
  assign ex.hilo_busy = (state_reg != S_IDLE);
  assign ex.hi        = hi_reg;
  assign ex.lo        = lo_reg;
  assign ex.hilo_done = done_reg;
  assign mul_opcode   = opcode_reg;
  assign mul_src1     = src1_reg;
  assign mul_src2     = src2_reg;

endmodule

// File: tb/tb_alu_hilo_unit.sv
// Bench for alu_hilo_unit: behavioural multiplier with a one-entry operand cache, directed
// commands, and a scoreboard monitor that checks HI/LO on every hilo_done pulse.
module tb_alu_hilo_unit;
  localparam int               OPC_W      = 5;
  localparam logic [OPC_W-1:0] OPC_IDLE   = 5'd0;
  localparam logic [OPC_W-1:0] OPC_MULTL  = 5'd24;
  localparam logic [OPC_W-1:0] OPC_MULTH  = 5'd25;
  localparam logic [OPC_W-1:0] OPC_MULTLU = 5'd26;
  localparam logic [OPC_W-1:0] OPC_MULTHU = 5'd27;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [OPC_W-1:0] mul_opcode;
  logic [31:0]      mul_src1, mul_src2;
  logic [31:0]      mul_result = '0;
  logic             mul_busy = 1'b0;
  logic             mul_done = 1'b0;

  alu_hilo_unit_if ex ();

  alu_hilo_unit #(
    .OPC_W(OPC_W), .OPC_IDLE(OPC_IDLE), .OPC_MULTL(OPC_MULTL), .OPC_MULTH(OPC_MULTH),
    .OPC_MULTLU(OPC_MULTLU), .OPC_MULTHU(OPC_MULTHU)
  ) dut (
    .CLK(clk), .RST(rst), .ex(ex),
    .mul_opcode(mul_opcode), .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_result(mul_result), .mul_busy(mul_busy), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb_q[$];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Multiplier model: a request matching the cached operands/signedness answers in one
  // cycle, otherwise in two cycles.
  function automatic logic [31:0] mul_calc(input logic [OPC_W-1:0] opc, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    if (opc == OPC_MULTL || opc == OPC_MULTH)
      p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    else
      p = {32'd0, a} * {32'd0, b};
    return (opc == OPC_MULTH || opc == OPC_MULTHU) ? p[63:32] : p[31:0];
  endfunction

  logic        cache_v = 1'b0, cache_s = 1'b0, pend = 1'b0;
  logic [31:0] cache_a = '0, cache_b = '0, pend_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      mul_done <= 1'b0;
      mul_busy <= 1'b0;
      cache_v  <= 1'b0;
      pend     <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      mul_busy <= 1'b0;
      if (pend) begin
        mul_done   <= 1'b1;
        mul_result <= pend_res;
        pend       <= 1'b0;
      end
      if (mul_opcode != OPC_IDLE) begin
        if (cache_v && mul_src1 == cache_a && mul_src2 == cache_b &&
            cache_s == (mul_opcode == OPC_MULTL || mul_opcode == OPC_MULTH)) begin
          mul_done   <= 1'b1;
          mul_result <= mul_calc(mul_opcode, mul_src1, mul_src2);
        end else begin
          pend     <= 1'b1;
          mul_busy <= 1'b1;
          pend_res <= mul_calc(mul_opcode, mul_src1, mul_src2);
          cache_v  <= 1'b1;
          cache_a  <= mul_src1;
          cache_b  <= mul_src2;
          cache_s  <= (mul_opcode == OPC_MULTL || mul_opcode == OPC_MULTH);
        end
      end
    end
  end

  // Scoreboard monitor: every hilo_done pulse must match the oldest outstanding multiply.
  always @(negedge clk) begin
    if (!rst && ex.hilo_done) begin
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check({ex.hi, ex.lo} == e, "sb_hilo", {ex.hi, ex.lo}, e);
        $display("done: hi=%h lo=%h", ex.hi, ex.lo);
      end
    end
  end

  // Issue a MULT/MULTU and follow it edge by edge; rst_mid asserts reset during HI_WAIT.
  task automatic do_mult(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit intrude, input bit rst_mid);
    logic [31:0] old_hi, old_lo;
    logic [OPC_W-1:0] opl, oph;
    int n, lo_edge;
    old_hi  = ex.hi;
    old_lo  = ex.lo;
    opl     = (c == 3'd1) ? OPC_MULTL : OPC_MULTLU;
    oph     = (c == 3'd1) ? OPC_MULTH : OPC_MULTHU;
    lo_edge = exp_cyc - 2;
    $display("cmd=%0d a=%h b=%h expect hi=%h lo=%h in %0d cycles", c, a, b, exp_hi, exp_lo, exp_cyc);
    ex.cmd_valid = 1'b1; ex.cmd = c; ex.cmd_a = a; ex.cmd_b = b;
    if (!rst_mid) sb_q.push_back({exp_hi, exp_lo});
    @(posedge clk);
    @(negedge clk);
    ex.cmd_valid = 1'b0;
    check(mul_opcode == opl, "lo_opcode", 64'(mul_opcode), 64'(opl));
    check(mul_src1 == a && mul_src2 == b, "operands", {mul_src1, mul_src2}, {a, b});
    n = 0;
    while (n < 40) begin
      if (n == 1) begin
        check(mul_opcode == OPC_IDLE, "opcode_one_cycle", 64'(mul_opcode), 64'(OPC_IDLE));
        if (intrude) begin
          ex.cmd_valid = 1'b1; ex.cmd = 3'd4; ex.cmd_a = 32'hDEADBEEF;
        end
      end
      if (n == 2) ex.cmd_valid = 1'b0;
      if (n == lo_edge - 1) check(ex.lo == old_lo, "lo_before", 64'(ex.lo), 64'(old_lo));
      if (n == lo_edge) begin
        check(ex.lo == exp_lo, "lo_capture", 64'(ex.lo), 64'(exp_lo));
        check(ex.hi == old_hi, "hi_old", 64'(ex.hi), 64'(old_hi));
        check(mul_opcode == oph, "hi_opcode", 64'(mul_opcode), 64'(oph));
      end
      if (rst_mid && n == 4) rst = 1'b1;
      if (rst_mid && n == 5) begin
        rst = 1'b0;
        check(ex.cmd_ready == 1'b1, "rst_ready", 64'(ex.cmd_ready), 64'd1);
        check({ex.hi, ex.lo} == 64'd0, "rst_hilo", {ex.hi, ex.lo}, 64'd0);
        check(ex.hilo_done == 1'b0, "rst_no_done", 64'(ex.hilo_done), 64'd0);
        break;
      end
      if (n > 0 && ex.cmd_ready) break;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!rst_mid) begin
      check(n == exp_cyc, "latency", 64'(n), 64'(exp_cyc));
      check(ex.hilo_busy == 1'b0, "busy_clear", 64'(ex.hilo_busy), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ex.cmd_valid = 1'b0; ex.cmd = '0; ex.cmd_a = '0; ex.cmd_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check({ex.hi, ex.lo} == 64'd0, "reset_hilo", {ex.hi, ex.lo}, 64'd0);
      check(ex.cmd_ready == 1'b1, "reset_ready", 64'(ex.cmd_ready), 64'd1);
      check(mul_opcode == OPC_IDLE, "reset_opcode", 64'(mul_opcode), 64'(OPC_IDLE));
      check(mul_src1 == 0 && mul_src2 == 0, "reset_src", {mul_src1, mul_src2}, 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    $display("idle after reset checked");

    do_mult(3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_mult(3'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_mult(3'd2, 32'hFFFFFFFF, 32'd2, 4, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_mult(3'd1, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h0, 1'b0, 1'b0);
    do_mult(3'd2, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h0, 1'b0, 1'b0);

    ex.cmd_valid = 1'b1; ex.cmd = 3'd3; ex.cmd_a = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    check(ex.hi == 32'h12345678, "mthi", 64'(ex.hi), 64'h12345678);
    check(ex.cmd_ready == 1'b1, "mthi_ready", 64'(ex.cmd_ready), 64'd1);
    ex.cmd = 3'd4; ex.cmd_a = 32'h9ABCDEF0;
    @(posedge clk);
    @(negedge clk);
    ex.cmd_valid = 1'b0;
    check(ex.lo == 32'h9ABCDEF0, "mtlo", 64'(ex.lo), 64'h9ABCDEF0);
    check(ex.hi == 32'h12345678, "mtlo_hi_kept", 64'(ex.hi), 64'h12345678);
    check(ex.cmd_ready == 1'b1, "mtlo_ready", 64'(ex.cmd_ready), 64'd1);
    check(ex.hilo_done == 1'b0, "mtlo_no_done", 64'(ex.hilo_done), 64'd0);
    $display("mthi/mtlo: hi=%h lo=%h", ex.hi, ex.lo);

    do_mult(3'd1, 32'd3, 32'd7, 5, 32'h0, 32'd21, 1'b1, 1'b0);
    do_mult(3'd1, 32'd7, 32'd9, 5, 32'h0, 32'd63, 1'b0, 1'b1);
    repeat (3) begin
      check(ex.hilo_done == 1'b0, "post_rst_quiet", 64'(ex.hilo_done), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    do_mult(3'd1, 32'd3, 32'd5, 5, 32'h0, 32'd15, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check(sb_q.size() == 0, "sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
